ray_sweep_sequencer: RTL and testbench

Frame-level ray sequencer for the raycaster. On each `start_frame` it walks every screen column left to right, computes the ray angle for that column from the player heading, drives the `begin_calc`/`end_calc` handshake of the wall-intersection finder, and latches the finder's result. It converts each result into a per-column distance record and hands the record to the column renderer over a valid/ready handshake. It is the initiator side of the intersection finder's protocol.

---
 rtl/ray_sweep_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ray_sweep_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_sweep_sequencer.sv
// ray_sweep_sequencer
//
// Frame-level ray sequencer for the raycaster. A start_frame pulse starts a
// sweep over every screen column, left to right. For each column the block
// issues a request to the wall-intersection finder with the column's ray
// angle. It waits for the finder's result, or gives up after TIMEOUT cycles.
// It then turns the result into a Manhattan-distance record and offers that
// record to the column renderer over a valid/ready handshake.
//
// Ports
//   clock, resetn            system clock; synchronous active-low reset
//   start_frame              start a sweep (sampled only while idle)
//   player_angle             heading in degrees 0..359, captured at start
//   playerX, playerY         player position, captured at start
//   alpha                    current ray angle to the finder, 0..359
//   begin_calc               one-cycle request to the finder
//   end_calc, wall_found     finder completion strobe and hit flag
//   wallX, wallY             finder intersection, valid with end_calc
//   col_valid / col_ready    record handshake to the renderer
//   col_index                column number 0..NUM_COLS-1
//   col_dist                 |dx|+|dy| to the wall, saturated to 12'hFFF
//   col_hit                  wall found for this column
//   busy                     high whenever the sequencer is not idle
//   frame_done               one-cycle pulse after the last record is taken
module ray_sweep_sequencer #(
    parameter int NUM_COLS = 320,
    parameter int FOV      = 60,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start_frame,
    input  logic [11:0] player_angle,
    input  logic [11:0] playerX,
    input  logic [11:0] playerY,
    output logic [11:0] alpha,
    output logic        begin_calc,
    input  logic        end_calc,
    input  logic        wall_found,
    input  logic [11:0] wallX,
    input  logic [11:0] wallY,
    output logic        col_valid,
    input  logic        col_ready,
    output logic [11:0] col_index,
    output logic [11:0] col_dist,
    output logic        col_hit,
    output logic        busy,
    output logic        frame_done
);

    // Angle accumulator: 9 integer bits (degrees) and 8 fractional bits.
    localparam logic [16:0] STEP     = 17'(FOV * 256 / NUM_COLS);
    localparam logic [16:0] FULL     = 17'(360 * 256);
    localparam logic [12:0] HALF_FOV = 13'(FOV / 2);
    localparam logic [11:0] LAST_COL = 12'(NUM_COLS - 1);
    localparam int          WW       = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DIST,
        OUT,
        NEXT,
        DONE
    } state_t;

    state_t        state;
    logic [16:0]   acc;
    logic [WW-1:0] wait_cnt;
    logic [11:0]   px_q;
    logic [11:0]   py_q;
    logic [11:0]   lat_x;
    logic [11:0]   lat_y;
    logic          lat_hit;

    // Start angle: the leftmost column sits FOV/2 counter-clockwise of the heading.
    logic [12:0] ang_sum;
    logic [8:0]  ang_start;
    always_comb begin
        ang_sum   = {1'b0, player_angle} + HALF_FOV;
        ang_start = (ang_sum >= 13'd360) ? 9'(ang_sum - 13'd360) : 9'(ang_sum);
    end

    // Step one column clockwise. If the step would go below 0 degrees,
    // wrap the angle back up through 360 degrees.
    logic [16:0] acc_next;
    always_comb begin
        if (acc < STEP)
            acc_next = acc + FULL - STEP;
        else
            acc_next = acc - STEP;
    end

    // Manhattan distance, computed one bit wider so saturation can be detected.
    logic [11:0] dx;
    logic [11:0] dy;
    logic [12:0] dsum;
    always_comb begin
        dx   = (lat_x >= px_q) ? (lat_x - px_q) : (px_q - lat_x);
        dy   = (lat_y >= py_q) ? (lat_y - py_q) : (py_q - lat_y);
        dsum = {1'b0, dx} + {1'b0, dy};
    end

    assign alpha = {3'b000, acc[16:8]};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            acc        <= '0;
            wait_cnt   <= '0;
            px_q       <= '0;
            py_q       <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_hit    <= 1'b0;
            begin_calc <= 1'b0;
            col_valid  <= 1'b0;
            col_index  <= '0;
            col_dist   <= '0;
            col_hit    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            begin_calc <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        px_q       <= playerX;
                        py_q       <= playerY;
                        acc        <= {ang_start, 8'd0};
                        col_index  <= '0;
                        begin_calc <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // On the first WAIT cycle end_calc may still be the finder's
                    // level from the previous ray, so it is not trusted then.
                    // A result arriving on the last allowed cycle still counts.
                    if (wait_cnt != '0 && end_calc) begin
                        lat_x   <= wallX;
                        lat_y   <= wallY;
                        lat_hit <= wall_found;
                        state   <= DIST;
                    end else if (wait_cnt == WAIT_LAST) begin
                        lat_hit <= 1'b0;
                        state   <= DIST;
                    end
                end
                DIST: begin
                    if (lat_hit)
                        col_dist <= dsum[12] ? 12'hFFF : dsum[11:0];
                    else
                        col_dist <= 12'hFFF;
                    col_hit   <= lat_hit;
                    col_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (col_ready) begin
                        col_valid <= 1'b0;
                        if (col_index == LAST_COL) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    col_index  <= col_index + 12'd1;
                    acc        <= acc_next;
                    begin_calc <= 1'b1;
                    state      <= ISSUE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_sweep_sequencer.sv
// Bench for ray_sweep_sequencer (4 columns, 60 degree FOV, 15-cycle timeout).
// A finder model answers each begin_calc and logs the answer it gave.
// A monitor logs every request, record and frame_done with its cycle number.
// Each test compares those logs against angles and distances worked out
// from the player pose and the finder answers.
module tb_ray_sweep_sequencer;

    localparam int NC   = 4;
    localparam int FV   = 60;
    localparam int TO   = 15;
    localparam int STEP = FV * 256 / NC;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start_frame = 1'b0;
    logic [11:0] player_angle = '0;
    logic [11:0] playerX = '0;
    logic [11:0] playerY = '0;
    logic [11:0] alpha;
    logic        begin_calc;
    logic        end_calc = 1'b0;
    logic        wall_found = 1'b0;
    logic [11:0] wallX = '0;
    logic [11:0] wallY = '0;
    logic        col_valid;
    logic        col_ready = 1'b0;
    logic [11:0] col_index;
    logic [11:0] col_dist;
    logic        col_hit;
    logic        busy;
    logic        frame_done;

    ray_sweep_sequencer #(.NUM_COLS(NC), .FOV(FV), .TIMEOUT(TO)) dut (
        .clock(clock), .resetn(resetn), .start_frame(start_frame),
        .player_angle(player_angle), .playerX(playerX), .playerY(playerY),
        .alpha(alpha), .begin_calc(begin_calc), .end_calc(end_calc),
        .wall_found(wall_found), .wallX(wallX), .wallY(wallY),
        .col_valid(col_valid), .col_ready(col_ready), .col_index(col_index),
        .col_dist(col_dist), .col_hit(col_hit), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk, n_pass;

    // finder model controls: 0 = answer after a delay, 1 = never answer,
    // 2 = hold end_calc high with fixed coordinates
    int          fin_mode = 0;
    logic        fix_en = 1'b0;
    logic [11:0] fix_x = '0, fix_y = '0;
    logic        fix_hit = 1'b0;
    int          fix_d = 1;
    logic        rdy_stall = 1'b0, rdy_rand = 1'b0, stall_col2 = 1'b0;

    // finder answers given, in ray order
    logic [11:0] q_wx[$];
    logic [11:0] q_wy[$];
    logic        q_wh[$];
    // monitor logs
    int          q_bc[$];
    int          q_alpha[$];
    int          q_vr[$];
    int          q_acc[$];
    int          q_idx[$];
    int          q_dist[$];
    int          q_hit[$];
    int          q_fd[$];

    logic [11:0] dr_x, dr_y;
    logic        dr_h;
    int          dr_d;

    always @(negedge clock) begin
        if (fin_mode == 2) begin
            end_calc   = 1'b1;
            wallX      = fix_x;
            wallY      = fix_y;
            wall_found = fix_hit;
            if (resetn && begin_calc) begin
                q_wx.push_back(fix_x); q_wy.push_back(fix_y); q_wh.push_back(fix_hit);
            end
        end else begin
            end_calc = 1'b0;
            if (resetn && begin_calc) begin
                if (fin_mode == 1) begin
                    q_wx.push_back(12'd0); q_wy.push_back(12'd0); q_wh.push_back(1'b0);
                end else begin
                    if (fix_en) begin
                        dr_x = fix_x; dr_y = fix_y; dr_h = fix_hit; dr_d = fix_d;
                    end else begin
                        dr_x = 12'($urandom); dr_y = 12'($urandom);
                        dr_h = ($urandom_range(0, 3) != 0); dr_d = $urandom_range(1, 12);
                    end
                    q_wx.push_back(dr_x); q_wy.push_back(dr_y); q_wh.push_back(dr_h);
                    // answer on WAIT cycle dr_d (the first WAIT cycle is 0)
                    repeat (dr_d + 1) @(negedge clock);
                    wallX = dr_x; wallY = dr_y; wall_found = dr_h; end_calc = 1'b1;
                    @(negedge clock);
                    end_calc = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (rdy_stall || (stall_col2 && col_index == 12'd2))
            col_ready = 1'b0;
        else if (rdy_rand)
            col_ready = ($urandom_range(0, 3) != 0);
        else
            col_ready = 1'b1;
    end

    logic v_prev = 1'b0;
    always @(negedge clock) begin
        #1;
        if (resetn) begin
            if (begin_calc) begin q_bc.push_back(cyc); q_alpha.push_back(int'(alpha)); end
            if (col_valid && !v_prev) q_vr.push_back(cyc);
            if (col_valid && col_ready) begin
                q_acc.push_back(cyc); q_idx.push_back(int'(col_index));
                q_dist.push_back(int'(col_dist)); q_hit.push_back(int'(col_hit));
            end
            if (frame_done) q_fd.push_back(cyc);
        end
        v_prev = col_valid;
    end

    // ---------------- reference model ----------------
    function automatic int exp_alpha(input int pa, input int i);
        int a;
        a = ((pa + FV / 2) % 360) * 256 - i * STEP;
        while (a < 0) a += 360 * 256;
        return a / 256;
    endfunction

    function automatic int exp_dist(input int wx, input int wy, input logic h, input int px, input int py);
        int s;
        if (!h) return 4095;
        s = ((wx > px) ? wx - px : px - wx) + ((wy > py) ? wy - py : py - wy);
        return (s > 4095) ? 4095 : s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic clear_q();
        q_wx.delete(); q_wy.delete(); q_wh.delete(); q_bc.delete(); q_alpha.delete();
        q_vr.delete(); q_acc.delete(); q_idx.delete(); q_dist.delete(); q_hit.delete(); q_fd.delete();
    endtask

    task automatic settle();
        repeat (20) tick();
        clear_q();
    endtask

    task automatic begin_frame(input int pa, input logic [11:0] x, input logic [11:0] y);
        player_angle = 12'(pa); playerX = x; playerY = y;
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0, k;
        n0 = q_fd.size(); k = 0;
        while (q_fd.size() == n0 && k < budget) begin tick(); k++; end
        n_chk++;
        if (q_fd.size() == n0) $display("FAIL frame_done_wait: got none within %0d cycles, expected a pulse", budget);
        else n_pass++;
        tick(); tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        n_chk++; if ({busy, begin_calc, col_valid, frame_done, col_hit} !== 5'b0)
            $display("FAIL reset_flags: got %b, expected 00000", {busy, begin_calc, col_valid, frame_done, col_hit}); else n_pass++;
        n_chk++; if (alpha !== 12'd0) $display("FAIL reset_alpha: got %0d, expected 0", alpha); else n_pass++;
        n_chk++; if (col_index !== 12'd0) $display("FAIL reset_index: got %0d, expected 0", col_index); else n_pass++;
        n_chk++; if (col_dist !== 12'd0) $display("FAIL reset_dist: got %0d, expected 0", col_dist); else n_pass++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_ray();
        settle();
        fin_mode = 0; fix_en = 1'b1; fix_x = 12'd100; fix_y = 12'd63; fix_hit = 1'b1; fix_d = 2;
        rdy_rand = 1'b0;
        begin_frame(90, 12'd100, 12'd100);
        wait_done(300);
        n_chk++; if (q_acc.size() !== NC) $display("FAIL single_count: got %0d, expected %0d", q_acc.size(), NC); else n_pass++;
        n_chk++; if (q_alpha[0] !== 120) $display("FAIL single_alpha: got %0d, expected 120", q_alpha[0]); else n_pass++;
        n_chk++; if (q_idx[0] !== 0) $display("FAIL single_index: got %0d, expected 0", q_idx[0]); else n_pass++;
        n_chk++; if (q_dist[0] !== 37) $display("FAIL single_dist: got %0d, expected 37", q_dist[0]); else n_pass++;
        n_chk++; if (q_hit[0] !== 1) $display("FAIL single_hit: got %0d, expected 1", q_hit[0]); else n_pass++;
        // answer on WAIT cycle 2 -> DIST, then valid: 5 cycles after the request
        n_chk++; if (q_vr[0] - q_bc[0] !== 5) $display("FAIL single_latency: got %0d, expected 5", q_vr[0] - q_bc[0]); else n_pass++;
        n_chk++; if (q_fd.size() !== 1) $display("FAIL single_done_pulses: got %0d, expected 1", q_fd.size()); else n_pass++;
        n_chk++; if (q_fd[0] - q_acc[NC-1] !== 1) $display("FAIL single_done_delay: got %0d, expected 1", q_fd[0] - q_acc[NC-1]); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %0d, expected 0", busy); else n_pass++;
        fix_en = 1'b0;
    endtask

    task automatic test_wrap();
        int want[4];
        logic [11:0] px, py;
        settle();
        want[0] = 40; want[1] = 25; want[2] = 10; want[3] = 355;
        fin_mode = 0; fix_en = 1'b0; rdy_rand = 1'b0;
        px = 12'($urandom); py = 12'($urandom);
        begin_frame(10, px, py);
        wait_done(400);
        n_chk++; if (q_acc.size() !== NC) $display("FAIL wrap_count: got %0d, expected %0d", q_acc.size(), NC); else n_pass++;
        for (int i = 0; i < NC && i < q_acc.size(); i++) begin
            n_chk++; if (q_alpha[i] !== want[i]) $display("FAIL wrap_alpha%0d: got %0d, expected %0d", i, q_alpha[i], want[i]); else n_pass++;
            n_chk++; if (q_idx[i] !== i) $display("FAIL wrap_index%0d: got %0d, expected %0d", i, q_idx[i], i); else n_pass++;
            n_chk++; if (q_dist[i] !== exp_dist(q_wx[i], q_wy[i], q_wh[i], px, py))
                $display("FAIL wrap_dist%0d: got %0d, expected %0d", i, q_dist[i], exp_dist(q_wx[i], q_wy[i], q_wh[i], px, py)); else n_pass++;
            if (i < NC - 1) begin
                n_chk++; if (q_bc[i+1] - q_acc[i] !== 2)
                    $display("FAIL wrap_next_issue%0d: got %0d, expected 2", i, q_bc[i+1] - q_acc[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_stall_stale();
        int k;
        logic [11:0] si, sd;
        logic sh, stable;
        settle();
        fin_mode = 2; fix_x = 12'd300; fix_y = 12'd50; fix_hit = 1'b1; rdy_rand = 1'b0; rdy_stall = 1'b1;
        tick(); tick();
        begin_frame(180, 12'd200, 12'd20);
        k = 0;
        while (!col_valid && k < 100) begin tick(); k++; end
        n_chk++; if (col_valid !== 1'b1) $display("FAIL stall_valid: got %0d, expected 1", col_valid); else n_pass++;
        si = col_index; sd = col_dist; sh = col_hit; stable = 1'b1;
        repeat (20) begin
            tick();
            if (col_valid !== 1'b1 || col_index !== si || col_dist !== sd || col_hit !== sh) stable = 1'b0;
        end
        n_chk++; if (stable !== 1'b1) $display("FAIL stall_stable: got %0d, expected 1", stable); else n_pass++;
        n_chk++; if (sd !== 12'd130) $display("FAIL stall_dist: got %0d, expected 130", sd); else n_pass++;
        rdy_stall = 1'b0;
        wait_done(300);
        n_chk++; if (q_bc.size() !== NC) $display("FAIL stale_requests: got %0d, expected %0d", q_bc.size(), NC); else n_pass++;
        for (int i = 0; i < NC && i < q_vr.size() && i < q_bc.size(); i++) begin
            // earliest acceptance is the second WAIT cycle -> valid 4 cycles after request
            n_chk++; if (q_vr[i] - q_bc[i] !== 4) $display("FAIL stale_latency%0d: got %0d, expected 4", i, q_vr[i] - q_bc[i]); else n_pass++;
        end
        fin_mode = 0;
    endtask

    task automatic test_timeout();
        settle();
        fin_mode = 1; rdy_rand = 1'b0;
        begin_frame(200, 12'd7, 12'd9);
        wait_done(400);
        n_chk++; if (q_acc.size() !== NC) $display("FAIL timeout_count: got %0d, expected %0d", q_acc.size(), NC); else n_pass++;
        n_chk++; if (q_vr[0] - q_bc[0] !== TO + 2) $display("FAIL timeout_latency: got %0d, expected %0d", q_vr[0] - q_bc[0], TO + 2); else n_pass++;
        for (int i = 0; i < q_acc.size(); i++) begin
            n_chk++; if (q_dist[i] !== 4095 || q_hit[i] !== 0)
                $display("FAIL timeout_rec%0d: got dist %0d hit %0d, expected dist 4095 hit 0", i, q_dist[i], q_hit[i]); else n_pass++;
        end
        fin_mode = 0;
    endtask

    task automatic test_saturation();
        settle();
        fin_mode = 0; fix_en = 1'b1; fix_x = 12'hFFF; fix_y = 12'hFFF; fix_hit = 1'b1; fix_d = 1; rdy_rand = 1'b0;
        begin_frame(0, 12'd0, 12'd0);
        wait_done(300);
        n_chk++; if (q_acc.size() !== NC) $display("FAIL sat_count: got %0d, expected %0d", q_acc.size(), NC); else n_pass++;
        for (int i = 0; i < q_acc.size(); i++) begin
            n_chk++; if (q_dist[i] !== 4095 || q_hit[i] !== 1)
                $display("FAIL sat_rec%0d: got dist %0d hit %0d, expected dist 4095 hit 1", i, q_dist[i], q_hit[i]); else n_pass++;
        end
        settle();
        fix_x = 12'd5; fix_y = 12'd5; fix_hit = 1'b0;
        begin_frame(0, 12'd0, 12'd0);
        wait_done(300);
        for (int i = 0; i < q_acc.size(); i++) begin
            n_chk++; if (q_dist[i] !== 4095 || q_hit[i] !== 0)
                $display("FAIL miss_rec%0d: got dist %0d hit %0d, expected dist 4095 hit 0", i, q_dist[i], q_hit[i]); else n_pass++;
        end
        fix_en = 1'b0;
    endtask

    task automatic test_ignored_start();
        int k;
        settle();
        fin_mode = 0; rdy_rand = 1'b1;
        begin_frame(300, 12'd1000, 12'd2000);
        k = 0;
        while (q_bc.size() < 2 && k < 200) begin tick(); k++; end
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        wait_done(600);
        repeat (10) tick();
        n_chk++; if (q_bc.size() !== NC) $display("FAIL ignstart_requests: got %0d, expected %0d", q_bc.size(), NC); else n_pass++;
        n_chk++; if (q_acc.size() !== NC) $display("FAIL ignstart_records: got %0d, expected %0d", q_acc.size(), NC); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL ignstart_busy: got %0d, expected 0", busy); else n_pass++;
        rdy_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        settle();
        fin_mode = 0; rdy_rand = 1'b0; stall_col2 = 1'b1;
        begin_frame(45, 12'd50, 12'd60);
        k = 0;
        while (!(col_valid && col_index == 12'd2) && k < 400) begin tick(); k++; end
        n_chk++; if (!(col_valid && col_index == 12'd2)) $display("FAIL rstmid_reach: got index %0d valid %0d, expected index 2 valid 1", col_index, col_valid); else n_pass++;
        resetn = 1'b0;
        tick();
        n_chk++; if ({busy, begin_calc, col_valid, frame_done, col_hit} !== 5'b0)
            $display("FAIL rstmid_flags: got %b, expected 00000", {busy, begin_calc, col_valid, frame_done, col_hit}); else n_pass++;
        n_chk++; if (alpha !== 12'd0 || col_index !== 12'd0 || col_dist !== 12'd0)
            $display("FAIL rstmid_values: got alpha %0d index %0d dist %0d, expected 0 0 0", alpha, col_index, col_dist); else n_pass++;
        resetn = 1'b1;
        stall_col2 = 1'b0;
        repeat (5) tick();
        n_chk++; if (q_acc.size() !== 2) $display("FAIL rstmid_records: got %0d, expected 2", q_acc.size()); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_idle: got busy %0d, expected 0", busy); else n_pass++;
    endtask

    task automatic test_random();
        int pa;
        logic [11:0] px, py;
        for (int f = 0; f < 4; f++) begin
            settle();
            fin_mode = 0; fix_en = 1'b0; rdy_rand = 1'b1;
            pa = $urandom_range(0, 359); px = 12'($urandom); py = 12'($urandom);
            begin_frame(pa, px, py);
            wait_done(800);
            n_chk++; if (q_acc.size() !== NC) $display("FAIL rand%0d_count: got %0d, expected %0d", f, q_acc.size(), NC); else n_pass++;
            for (int i = 0; i < NC && i < q_acc.size() && i < q_wx.size(); i++) begin
                n_chk++; if (q_alpha[i] !== exp_alpha(pa, i))
                    $display("FAIL rand%0d_alpha%0d: got %0d, expected %0d", f, i, q_alpha[i], exp_alpha(pa, i)); else n_pass++;
                n_chk++; if (q_idx[i] !== i) $display("FAIL rand%0d_index%0d: got %0d, expected %0d", f, i, q_idx[i], i); else n_pass++;
                n_chk++; if (q_dist[i] !== exp_dist(q_wx[i], q_wy[i], q_wh[i], px, py))
                    $display("FAIL rand%0d_dist%0d: got %0d, expected %0d", f, i, q_dist[i], exp_dist(q_wx[i], q_wy[i], q_wh[i], px, py)); else n_pass++;
                n_chk++; if (q_hit[i] !== int'(q_wh[i])) $display("FAIL rand%0d_hit%0d: got %0d, expected %0d", f, i, q_hit[i], q_wh[i]); else n_pass++;
            end
        end
        rdy_rand = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_single_ray();
        test_wrap();
        test_stall_stale();
        test_timeout();
        test_saturation();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
